// File: rtl/fir_lpf_serial.sv
// 16-tap symmetric low-pass FIR with a single serial MAC.
// One output is produced per sampling-clock rising edge.
module fir_lpf_serial #(
    parameter int TAPS   = 16,
    parameter int DATA_W = 12,
    parameter int COEF_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_clk,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              ovr
);

    localparam int unsigned ACC_W  = 28;
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned IDX_W  = $clog2(TAPS);
    localparam int unsigned FRAC_W = COEF_W - 1;

    localparam logic [IDX_W-1:0]        LAST_K   = IDX_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (FRAC_W - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(-(1 << (DATA_W - 1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ROUND,
        S_OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic                      s_clk_q;
    logic                      armed;
    logic                      rise_c;
    logic                      edge_q;
    logic signed [DATA_W-1:0]  smp;
    logic signed [DATA_W-1:0]  x [TAPS];
    logic        [IDX_W-1:0]   k;
    logic signed [ACC_W-1:0]   acc;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   rsum;
    logic signed [ACC_W-1:0]   rsh;
    logic signed [DATA_W-1:0]  y_c;
    logic signed [DATA_W-1:0]  y_q;

    // Symmetric ROM: the upper half mirrors the lower half (c[15-k] = c[k]).
    function automatic logic signed [COEF_W-1:0] coef(input logic [IDX_W-1:0] idx);
        logic [2:0] m;
        m = idx[IDX_W-1] ? ~idx[2:0] : idx[2:0];
        case (m)
            3'd0:    coef = COEF_W'(8);
            3'd1:    coef = COEF_W'(16);
            3'd2:    coef = COEF_W'(40);
            3'd3:    coef = COEF_W'(80);
            3'd4:    coef = COEF_W'(136);
            3'd5:    coef = COEF_W'(192);
            3'd6:    coef = COEF_W'(240);
            3'd7:    coef = COEF_W'(312);
            default: coef = '0;
        endcase
    endfunction

    // armed blocks an edge after reset until s_clk has been seen low
    assign rise_c = s_clk & ~s_clk_q & en & armed;

    assign prod = x[k] * coef(k);
    assign rsum = acc + RND_HALF;
    assign rsh  = rsum >>> FRAC_W;
    assign y_c  = (rsh > SAT_HI) ? DATA_W'(SAT_HI) :
                  (rsh < SAT_LO) ? DATA_W'(SAT_LO) : DATA_W'(rsh);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (edge_q) state_next = S_MAC;
            S_MAC:   if (k == LAST_K) state_next = S_ROUND;
            S_ROUND: state_next = S_OUT;
            S_OUT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; edges arriving while busy are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_clk_q    <= 1'b0;
            armed      <= 1'b0;
            edge_q     <= 1'b0;
            smp        <= '0;
            k          <= '0;
            acc        <= '0;
            y_q        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            ovr        <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
        end else begin
            s_clk_q    <= s_clk;
            armed      <= armed | ~s_clk;
            edge_q     <= rise_c;
            dout_valid <= 1'b0;
            busy       <= (state_next != S_IDLE);
            if (rise_c) begin
                smp <= din;
            end
            if (edge_q && state == S_IDLE) begin
                for (int i = TAPS - 1; i > 0; i--) begin
                    x[i] <= x[i-1];
                end
                x[0] <= smp;
                acc  <= '0;
                k    <= '0;
            end
            if (edge_q && state != S_IDLE) begin
                ovr <= 1'b1;
            end
            if (state == S_MAC) begin
                acc <= acc + ACC_W'(prod);
                k   <= k + IDX_W'(1);
            end
            if (state == S_ROUND) begin
                y_q <= y_c;
            end
            if (state == S_OUT) begin
                dout       <= y_q;
                dout_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_lpf_serial.sv
// Directed bench for fir_lpf_serial: impulse, DC, latency, overrun, reset, enable.
module tb_fir_lpf_serial;

    logic               clk   = 1'b0;
    logic               rst   = 1'b1;
    logic               s_clk = 1'b0;
    logic               en    = 1'b0;
    logic signed [11:0] din   = '0;
    logic [11:0]        dout;
    logic               dout_valid;
    logic               busy;
    logic               ovr;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int outq[$];
    int tq[$];
    int riseq[$];

    int imp_exp[17] = '{8, 16, 40, 80, 136, 192, 240, 312, 312, 240, 192, 136, 80, 40, 16, 8, 0};

    fir_lpf_serial #(.TAPS(16), .DATA_W(12), .COEF_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_clk      (s_clk),
        .en         (en),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .ovr        (ovr)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && dout_valid) begin
            outq.push_back(int'($signed(dout)));
            tq.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; s_clk = 1'b0; din = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        outq.delete(); tq.delete(); riseq.delete();
    endtask

    // One 25-clk sample period: s_clk high for 12 clk, low for 13.
    task automatic drive_sample(input int d);
        @(negedge clk);
        din = 12'(d); s_clk = 1'b1;
        riseq.push_back(cyc + 1);
        repeat (12) @(negedge clk);
        s_clk = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({dout, dout_valid, busy, ovr} !== 15'd0)
            $display("FAIL reset_outputs: got dout=%0d valid=%0b busy=%0b ovr=%0b, want all 0",
                     $signed(dout), dout_valid, busy, ovr);
        else passes++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_impulse();
        do_reset(); en = 1'b1;
        drive_sample(2047);
        for (int i = 0; i < 16; i++) drive_sample(0);
        checks++;
        if (outq.size() != 17) $display("FAIL impulse_count: got %0d, want 17", outq.size());
        else passes++;
        for (int i = 0; i < 17 && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== imp_exp[i]) $display("FAIL impulse_%0d: got %0d, want %0d", i, outq[i], imp_exp[i]);
            else passes++;
            checks++;
            if (tq[i] - riseq[i] !== 19)
                $display("FAIL latency_%0d: got %0d clk, want 19", i, tq[i] - riseq[i]);
            else passes++;
        end
    endtask

    task automatic test_busy();
        int r;
        do_reset(); en = 1'b1;
        @(negedge clk);
        din = 12'sd100; s_clk = 1'b1; r = cyc + 1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_detect: got %0b at cyc %0d, want 0", busy, cyc - r);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_start: got %0b, want 1", busy);
        else passes++;
        repeat (17) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || dout_valid !== 1'b0)
            $display("FAIL busy_out: got busy=%0b valid=%0b, want 1/0", busy, dout_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b1 || cyc - r !== 19)
            $display("FAIL busy_end: got busy=%0b valid=%0b at +%0d, want 0/1 at +19", busy, dout_valid, cyc - r);
        else passes++;
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b0) $display("FAIL valid_pulse: got %0b, want 0", dout_valid);
        else passes++;
        s_clk = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_dc();
        do_reset(); en = 1'b1;
        for (int i = 0; i < 17; i++) drive_sample(1000);
        for (int i = 0; i < 17; i++) drive_sample(-2048);
        checks++;
        if (outq.size() != 34) $display("FAIL dc_count: got %0d, want 34", outq.size());
        else begin
            passes++;
            checks++;
            if (outq[0] !== 4) $display("FAIL dc_first: got %0d, want 4", outq[0]);
            else passes++;
            checks++;
            if (outq[15] !== 1000 || outq[16] !== 1000)
                $display("FAIL dc_pos: got %0d,%0d, want 1000,1000", outq[15], outq[16]);
            else passes++;
            checks++;
            if (outq[32] !== -2048 || outq[33] !== -2048)
                $display("FAIL dc_neg: got %0d,%0d, want -2048,-2048", outq[32], outq[33]);
            else passes++;
        end
    endtask

    task automatic test_overrun();
        do_reset(); en = 1'b1;
        checks++;
        if (ovr !== 1'b0) $display("FAIL ovr_clear: got %0b, want 0", ovr);
        else passes++;
        @(negedge clk);
        din = 12'sd2047; s_clk = 1'b1;
        repeat (5) @(negedge clk);
        s_clk = 1'b0;
        repeat (5) @(negedge clk);
        din = 12'sd1000; s_clk = 1'b1;
        repeat (5) @(negedge clk);
        s_clk = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (ovr !== 1'b1) $display("FAIL ovr_set: got %0b, want 1", ovr);
        else passes++;
        drive_sample(0);
        drive_sample(0);
        checks++;
        if (outq.size() != 3) $display("FAIL ovr_count: got %0d, want 3", outq.size());
        else begin
            passes++;
            checks++;
            if (outq[0] !== 8 || outq[1] !== 16 || outq[2] !== 40)
                $display("FAIL ovr_seq: got %0d,%0d,%0d, want 8,16,40", outq[0], outq[1], outq[2]);
            else passes++;
        end
        checks++;
        if (ovr !== 1'b1) $display("FAIL ovr_sticky: got %0b, want 1", ovr);
        else passes++;
    endtask

    task automatic test_reset_mid_mac();
        do_reset(); en = 1'b1;
        @(negedge clk);
        din = 12'sd2047; s_clk = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL mid_mac_busy: got %0b, want 1", busy);
        else passes++;
        rst = 1'b0;
        #1;
        checks++;
        if ({dout, dout_valid, busy, ovr} !== 15'd0)
            $display("FAIL mid_mac_clear: got dout=%0d valid=%0b busy=%0b ovr=%0b, want all 0",
                     $signed(dout), dout_valid, busy, ovr);
        else passes++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (outq.size() != 0 || busy !== 1'b0)
            $display("FAIL held_high_after_reset: got outputs=%0d busy=%0b, want 0/0", outq.size(), busy);
        else passes++;
        s_clk = 1'b0;
        repeat (5) @(negedge clk);
        drive_sample(2047);
        drive_sample(0);
        checks++;
        if (outq.size() != 2) $display("FAIL mid_mac_count: got %0d, want 2", outq.size());
        else begin
            passes++;
            checks++;
            if (outq[0] !== 8 || outq[1] !== 16)
                $display("FAIL mid_mac_impulse: got %0d,%0d, want 8,16", outq[0], outq[1]);
            else passes++;
        end
    endtask

    task automatic test_enable();
        do_reset(); en = 1'b1;
        drive_sample(2047);
        @(negedge clk);
        din = 12'sd0; s_clk = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b0;
        repeat (7) @(negedge clk);
        s_clk = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_sample(1000);
        checks++;
        if (outq.size() != 2) $display("FAIL en_frozen_count: got %0d, want 2", outq.size());
        else passes++;
        en = 1'b1;
        drive_sample(0);
        checks++;
        if (outq.size() != 3) $display("FAIL en_resume_count: got %0d, want 3", outq.size());
        else begin
            passes++;
            checks++;
            if (outq[1] !== 16 || outq[2] !== 40)
                $display("FAIL en_seq: got %0d,%0d, want 16,40", outq[1], outq[2]);
            else passes++;
        end
    endtask

    task automatic test_hold();
        do_reset(); en = 1'b1;
        @(negedge clk);
        din = 12'sd2047; s_clk = 1'b1;
        repeat (70) @(negedge clk);
        s_clk = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (outq.size() != 1) $display("FAIL hold_count: got %0d, want 1", outq.size());
        else begin
            passes++;
            checks++;
            if (outq[0] !== 8) $display("FAIL hold_value: got %0d, want 8", outq[0]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_busy();
        test_dc();
        test_overrun();
        test_reset_mid_mac();
        test_enable();
        test_hold();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
